// File: rtl/uart_arb_pkg.sv
// Shared state encoding and constants for the UART transmit scheduler and
// receive buffer.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_LOCK,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GUARD
  } state_e;

  localparam int CHAR_BITS_DEF = 10;

  // The measured rate drops the low 3 bits of the bit period, so every reload
  // fills them with ones and the period is never shorter than the real one.
  localparam logic [2:0] PER_LSB = 3'b111;

endpackage

// File: rtl/uart_arb_if.sv
// Requester, UART-side and receive-queue signals of uart_arb.
// The slave modport is the scheduler's view; master is the surrounding system.
interface uart_arb_if;

  logic [7:0] req0_data;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] uart_od;
  logic       uart_dox;
  logic [7:0] uart_rate;
  logic [7:0] uart_id;
  logic       uart_dix;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_ovf;
  logic       rx_ovf_clr;
  logic       tx_busy;
  logic       tx_owner;

  modport slave (
    input  req0_data, req0_valid, req1_data, req1_valid,
    input  uart_rate, uart_id, uart_dix, rx_ready, rx_ovf_clr,
    output req0_ready, req1_ready, uart_od, uart_dox,
    output rx_data, rx_valid, rx_ovf, tx_busy, tx_owner
  );

  modport master (
    output req0_data, req0_valid, req1_data, req1_valid,
    output uart_rate, uart_id, uart_dix, rx_ready, rx_ovf_clr,
    input  req0_ready, req1_ready, uart_od, uart_dox,
    input  rx_data, rx_valid, rx_ovf, tx_busy, tx_owner
  );

endinterface

// File: rtl/uart_rxbuf.sv
// Two-entry receive queue with a sticky overflow flag.
// The head is shown combinationally; a set beats a clear on the flag.
module uart_rxbuf (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  input  logic       clr_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       ovf_o
);

  logic [7:0] mem0_q, mem1_q;
  logic       rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic       pop, full, accept, drop, wr;

  // A pop on a full queue frees the head slot, which is exactly where the
  // simultaneous push lands (rd + 2 wraps back to rd).
  always_comb begin
    pop    = pop_i && (cnt_q != 2'd0);
    full   = (cnt_q == 2'd2);
    accept = push_i && (!full || pop);
    drop   = push_i && full && !pop;
    wr     = rd_q ^ cnt_q[0];
    rd_d   = rd_q ^ pop;
    cnt_d  = cnt_q + {1'b0, accept} - {1'b0, pop};
    ovf_d  = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem0_q <= 8'd0;
      mem1_q <= 8'd0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
      ovf_q  <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (accept && wr) begin
        mem1_q <= push_data_i;
      end else if (accept) begin
        mem0_q <= push_data_i;
      end
    end
  end

  assign data_o  = rd_q ? mem1_q : mem0_q;
  assign valid_o = (cnt_q != 2'd0);
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/uart_arb.sv
// Round-robin transmit scheduler for the autobaud UART: paces characters from
// the measured bit rate since the UART gives no busy indication.
module uart_arb
  import uart_arb_pkg::*;
#(
  parameter int GUARD     = 16,
  parameter int CHAR_BITS = CHAR_BITS_DEF
) (
  input logic       clk,
  input logic       reset,
  uart_arb_if.slave bus
);

  localparam int              GW         = $clog2(GUARD + 1);
  localparam logic [3:0]      BITS_LAST  = 4'(CHAR_BITS - 1);
  localparam logic [GW-1:0]   GUARD_LAST = GW'(GUARD - 1);

  state_e        state_q, state_d;
  logic [10:0]   percnt_q, percnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [7:0]    rate_q, rate_d;
  logic [7:0]    od_q, od_d;
  logic          owner_q, owner_d;
  logic          ptr_q, ptr_d;
  logic          gnt1, rdy0, rdy1, dox;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LOCK;
      percnt_q <= 11'd0;
      bitcnt_q <= 4'd0;
      gcnt_q   <= '0;
      rate_q   <= 8'd0;
      od_q     <= 8'd0;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      percnt_q <= percnt_d;
      bitcnt_q <= bitcnt_d;
      gcnt_q   <= gcnt_d;
      rate_q   <= rate_d;
      od_q     <= od_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
    end
  end

  // Leaving LOCK runs one full character time before the first grant, in case
  // the UART was mid-character when this block came out of reset.
  always_comb begin
    state_d  = state_q;
    percnt_d = percnt_q;
    bitcnt_d = bitcnt_q;
    gcnt_d   = gcnt_q;
    rate_d   = rate_q;
    od_d     = od_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    gnt1     = 1'b0;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    dox      = 1'b0;
    case (state_q)
      ST_LOCK: begin
        if (bus.uart_rate != 8'd0) begin
          rate_d   = bus.uart_rate;
          percnt_d = {bus.uart_rate, PER_LSB};
          bitcnt_d = BITS_LAST;
          state_d  = ST_WAIT;
        end
      end
      ST_IDLE: begin
        if (bus.uart_rate == 8'd0) begin
          state_d = ST_LOCK;
        end else begin
          gnt1 = bus.req1_valid && (!bus.req0_valid || ptr_q);
          rdy0 = bus.req0_valid && !gnt1;
          rdy1 = gnt1;
          if (rdy0 || rdy1) begin
            od_d    = gnt1 ? bus.req1_data : bus.req0_data;
            rate_d  = bus.uart_rate;
            owner_d = gnt1;
            ptr_d   = !gnt1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        dox      = 1'b1;
        bitcnt_d = BITS_LAST;
        percnt_d = {rate_q, PER_LSB};
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (percnt_q != 11'd0) begin
          percnt_d = percnt_q - 11'd1;
        end else if (bitcnt_q == 4'd0) begin
          gcnt_d  = GUARD_LAST;
          state_d = ST_GUARD;
        end else begin
          bitcnt_d = bitcnt_q - 4'd1;
          percnt_d = {rate_q, PER_LSB};
        end
      end
      ST_GUARD: begin
        if (gcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      default: state_d = ST_LOCK;
    endcase
  end

  logic [7:0] rx_data_w;
  logic       rx_valid_w, rx_ovf_w;

  uart_rxbuf u_rxbuf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (bus.uart_dix),
    .push_data_i (bus.uart_id),
    .pop_i       (bus.rx_ready),
    .clr_i       (bus.rx_ovf_clr),
    .data_o      (rx_data_w),
    .valid_o     (rx_valid_w),
    .ovf_o       (rx_ovf_w)
  );

  // Busy covers every pacing state; LOCK itself reads idle so that all
  // outputs are low straight out of reset.
  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.uart_od    = od_q;
  assign bus.uart_dox   = dox;
  assign bus.tx_owner   = owner_q;
  assign bus.tx_busy    = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                          (state_q == ST_GUARD);
  assign bus.rx_data    = rx_data_w;
  assign bus.rx_valid   = rx_valid_w;
  assign bus.rx_ovf     = rx_ovf_w;

endmodule

// File: tb/tb_uart_arb.sv
// Randomised scoreboard bench for uart_arb: a timing-level reference model
// predicts grants, strobes and queue contents from the character-time rules.
module tb_uart_arb;

  localparam int GUARD     = 16;
  localparam int CHAR_BITS = 10;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  uart_arb_if bus ();

  uart_arb #(.GUARD(GUARD), .CHAR_BITS(CHAR_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       owner;
    int         at;
  } tx_t;

  tx_t        txq[$];
  logic [7:0] rxq[$];
  int         nChecks = 0;
  int         nPass = 0;
  bit         locked = 1'b1;
  bit         lastGnt = 1'b1;
  int         freeAt = 0;
  int         transCyc = 0;
  logic [7:0] odExp = 8'd0;
  logic       ownerExp = 1'b0;
  bit         ovfExp = 1'b0;
  bit         acc0 = 1'b0;
  bit         acc1 = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s actual=%0h required=%0h cycle=%0d",
                  name, act, exp, cyc);
  endtask

  // Character time in cycles for a given measured rate.
  function automatic int charCycles(input int rate);
    return CHAR_BITS * (rate * 8 + 8);
  endfunction

  task automatic modelStep();
    int         r;
    bit         v0, v1, g, e0, e1, full, pop, drop;
    tx_t        t;
    r  = int'(bus.uart_rate);
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    e0 = 1'b0;
    e1 = 1'b0;
    if (txq.size() > 0 && txq[0].at <= cyc) begin
      t = txq.pop_front();
      checkOutput("dox_strobe", bus.uart_dox, 1);
      odExp    = t.data;
      ownerExp = t.owner;
    end else begin
      checkOutput("dox_quiet", bus.uart_dox, 0);
    end
    checkOutput("uart_od", bus.uart_od, odExp);
    checkOutput("tx_owner", bus.tx_owner, ownerExp);
    checkOutput("tx_busy", bus.tx_busy,
                (!locked && cyc > transCyc && cyc < freeAt) ? 1 : 0);
    if (locked) begin
      if (r != 0) begin
        locked   = 1'b0;
        transCyc = cyc;
        freeAt   = cyc + 1 + charCycles(r) + GUARD;
      end
    end else if (cyc >= freeAt) begin
      if (r == 0) begin
        locked = 1'b1;
      end else if (v0 || v1) begin
        g        = (v0 && v1) ? !lastGnt : v1;
        e0       = !g;
        e1       = g;
        lastGnt  = g;
        t.data   = g ? bus.req1_data : bus.req0_data;
        t.owner  = g;
        t.at     = cyc + 1;
        txq.push_back(t);
        transCyc = cyc;
        freeAt   = cyc + 2 + charCycles(r) + GUARD;
      end
    end
    checkOutput("req0_ready", bus.req0_ready, e0);
    checkOutput("req1_ready", bus.req1_ready, e1);
    acc0 = bus.req0_valid && bus.req0_ready;
    acc1 = bus.req1_valid && bus.req1_ready;

    checkOutput("rx_valid", bus.rx_valid, (rxq.size() > 0) ? 1 : 0);
    checkOutput("rx_ovf", bus.rx_ovf, ovfExp);
    full = (rxq.size() == 2);
    pop  = bus.rx_ready && (rxq.size() > 0);
    if (pop) checkOutput("rx_data_pop", bus.rx_data, rxq.pop_front());
    else if (rxq.size() > 0) checkOutput("rx_data_head", bus.rx_data, rxq[0]);
    drop = bus.uart_dix && full && !pop;
    if (bus.uart_dix && !drop) rxq.push_back(bus.uart_id);
    if (drop) ovfExp = 1'b1;
    else if (bus.rx_ovf_clr) ovfExp = 1'b0;
  endtask

  // Monitor and scoreboard: inputs are stable here, outputs settled.
  always @(negedge clk) begin
    if (reset) begin
      locked   = 1'b1;
      lastGnt  = 1'b1;
      odExp    = 8'd0;
      ownerExp = 1'b0;
      ovfExp   = 1'b0;
      acc0     = 1'b0;
      acc1     = 1'b0;
      txq.delete();
      rxq.delete();
      checkOutput("rst_ready0", bus.req0_ready, 0);
      checkOutput("rst_ready1", bus.req1_ready, 0);
      checkOutput("rst_od", bus.uart_od, 0);
      checkOutput("rst_dox", bus.uart_dox, 0);
      checkOutput("rst_busy", bus.tx_busy, 0);
      checkOutput("rst_owner", bus.tx_owner, 0);
      checkOutput("rst_rx_data", bus.rx_data, 0);
      checkOutput("rst_rx_valid", bus.rx_valid, 0);
      checkOutput("rst_rx_ovf", bus.rx_ovf, 0);
    end else begin
      modelStep();
    end
  end

  task automatic runRandom(input int n, input int maxRate);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (acc0 || !bus.req0_valid) begin
        bus.req0_valid = ($urandom_range(0, 3) != 0);
        bus.req0_data  = 8'($urandom);
      end
      if (acc1 || !bus.req1_valid) begin
        bus.req1_valid = ($urandom_range(0, 3) != 0);
        bus.req1_data  = 8'($urandom);
      end
      if (bus.uart_rate == 8'd0) begin
        if ($urandom_range(0, 49) == 0) bus.uart_rate = 8'($urandom_range(1, maxRate));
      end else if ($urandom_range(0, 399) == 0) begin
        bus.uart_rate = 8'($urandom_range(1, maxRate));
      end else if ($urandom_range(0, 1999) == 0) begin
        bus.uart_rate = 8'd0;
      end
      bus.uart_dix   = ($urandom_range(0, 3) == 0);
      bus.uart_id    = 8'($urandom);
      bus.rx_ready   = ($urandom_range(0, 2) == 0);
      bus.rx_ovf_clr = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic pushByte(input logic [7:0] b, input logic popToo);
    bus.uart_dix = 1'b1;
    bus.uart_id  = b;
    bus.rx_ready = popToo;
    @(posedge clk);
    #1;
    bus.uart_dix = 1'b0;
    bus.rx_ready = 1'b0;
  endtask

  task automatic rxOverflow();
    @(posedge clk);
    #1;
    bus.uart_dix   = 1'b0;
    bus.rx_ready   = 1'b1;
    bus.rx_ovf_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.rx_ready   = 1'b0;
    bus.rx_ovf_clr = 1'b0;
    pushByte(8'h11, 1'b0);
    pushByte(8'h22, 1'b0);
    pushByte(8'h33, 1'b0);
    repeat (2) @(posedge clk);
    #1 bus.rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.rx_ready = 1'b0;
    bus.rx_ovf_clr = 1'b1;
    @(posedge clk);
    #1 bus.rx_ovf_clr = 1'b0;
    pushByte(8'h44, 1'b0);
    pushByte(8'h55, 1'b0);
    pushByte(8'h66, 1'b1);
    @(posedge clk);
    #1 bus.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.rx_ready = 1'b0;
  endtask

  task automatic resetMidWait();
    bit seen = 1'b0;
    @(posedge clk);
    #1;
    bus.uart_rate  = 8'd4;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h5A;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = bus.uart_dox;
    end
    checkOutput("dox_before_reset", seen, 1);
    repeat (200) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic applyStimulus();
    reset          = 1'b1;
    bus.req0_data  = 8'h55;
    bus.req0_valid = 1'b0;
    bus.req1_data  = 8'h00;
    bus.req1_valid = 1'b0;
    bus.uart_rate  = 8'd0;
    bus.uart_id    = 8'd0;
    bus.uart_dix   = 1'b0;
    bus.rx_ready   = 1'b0;
    bus.rx_ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bus.req0_valid = 1'b1;
    repeat (1000) @(posedge clk);
    #1 bus.uart_rate = 8'd4;
    runRandom(8000, 8);
    rxOverflow();
    resetMidWait();
    runRandom(8000, 8);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.uart_dix   = 1'b0;
    bus.rx_ready   = 1'b1;
    bus.uart_rate  = 8'd4;
    repeat (1000) @(posedge clk);
  endtask

  initial begin
    applyStimulus();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
